// File: rtl/program_loader.sv
// Streams 16-bit words into instruction memory from addr 0, holding the CPU in reset until settled.
// Latency: a word is written 1 cycle after its handshake. cpu_resetn rises RELEASE_CYCLES after the last write.
// Backpressure: in_ready is registered and high only in LOAD/CHECK. PROGRAM_LOADER_CHECKSUM_EN adds a trailing checksum word.
module program_loader #(
   parameter int ADDR_W         = 8,
   parameter int DEPTH          = 256,
   parameter int RELEASE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_data,
   input  logic              in_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              cpu_resetn,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   localparam int              CNT_W    = $clog2(RELEASE_CYCLES + 1);
   localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_RELEASE,
      S_RUN,
      S_ERROR
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] rel_cnt;
   logic             hs;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [15:0]      sum;
`endif

   assign hs = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         rel_cnt    <= '0;
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_resetn <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         sum        <= '0;
`endif
      end else begin
         imem_we <= 1'b0;
         case (state)
            S_IDLE, S_RUN, S_ERROR: begin
               if (start) begin
                  state      <= S_LOAD;
                  in_ready   <= 1'b1;
                  word_count <= '0;
                  cpu_resetn <= 1'b0;
                  done       <= 1'b0;
                  error      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  sum        <= '0;
`endif
               end
            end
            S_LOAD: begin
               if (hs) begin
                  // A full memory rejects the word outright; the address never wraps.
                  if (word_count == DEPTH_W) begin
                     state    <= S_ERROR;
                     in_ready <= 1'b0;
                     error    <= 1'b1;
                  end else begin
                     imem_we    <= 1'b1;
                     imem_addr  <= word_count[ADDR_W-1:0];
                     imem_wdata <= in_data;
                     word_count <= word_count + 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                     sum        <= sum + in_data;
                     if (in_last) begin
                        state <= S_CHECK;
                     end
`else
                     if (in_last) begin
                        state    <= S_RELEASE;
                        in_ready <= 1'b0;
                        rel_cnt  <= '0;
                     end
`endif
                  end
               end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (hs) begin
                  in_ready <= 1'b0;
                  if (in_data == sum) begin
                     state   <= S_RELEASE;
                     rel_cnt <= '0;
                  end else begin
                     state <= S_ERROR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            S_RELEASE: begin
               if (rel_cnt == REL_LAST) begin
                  state      <= S_RUN;
                  cpu_resetn <= 1'b1;
                  done       <= 1'b1;
               end else begin
                  rel_cnt <= rel_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued when words are driven
// and checked against imem_we pulses; each task checks its own control/timing outputs.
module tb_program_loader;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 256;
   localparam int REL    = 4;

   logic              clk = 1'b0;
   logic              reset, start, in_valid, in_last;
   logic [15:0]       in_data;
   logic              in_ready, imem_we, cpu_resetn, done, error;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_wdata;
   logic [ADDR_W:0]   word_count;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
   } wr_t;

   int          vectors     = 0;
   int          miscompares = 0;
   wr_t         exp_q[$];
   logic [15:0] prog [0:DEPTH];
   logic [15:0] csum;

   program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RELEASE_CYCLES(REL)) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_resetn(cpu_resetn), .done(done), .error(error), .word_count(word_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      wr_t e;
      if (imem_we === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write addr=%0d data=%h required no write", imem_addr, imem_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({imem_addr, imem_wdata} !== {e.addr, e.data}) begin
               miscompares++;
               $display("FAIL write got addr=%0d data=%h required addr=%0d data=%h",
                        imem_addr, imem_wdata, e.addr, e.data);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      tick; tick;
      reset = 1'b0;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic send_prog(input int n, input bit with_last, input bit gap, input logic [15:0] delta);
      csum = '0;
      for (int i = 0; i < n; i++) begin
         if (gap) begin
            in_valid = 1'b0; in_data = 16'hffff; in_last = 1'b0;
            tick;
         end
         in_valid = 1'b1; in_data = prog[i]; in_last = with_last && (i == n - 1);
         vectors++;
         if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready_load word=%0d got=%b required=1", i, in_ready);
         end
         if (i < DEPTH) begin
            exp_q.push_back('{addr: ADDR_W'(i), data: prog[i]});
            csum = csum + prog[i];
         end
         tick;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (with_last) begin
         in_valid = 1'b1; in_data = csum + delta; in_last = 1'b1;
         tick;
      end
`endif
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic check_release(input int wc);
      for (int k = 0; k < REL; k++) begin
         vectors++;
         if (cpu_resetn !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL release_hold k=%0d got resetn=%b done=%b ready=%b required 0 0 0",
                     k, cpu_resetn, done, in_ready);
         end
         tick;
      end
      vectors++;
      if (cpu_resetn !== 1'b1 || done !== 1'b1 || error !== 1'b0) begin
         miscompares++;
         $display("FAIL release_rise got resetn=%b done=%b error=%b required 1 1 0", cpu_resetn, done, error);
      end
      vectors++;
      if (word_count !== (ADDR_W + 1)'(wc)) begin
         miscompares++;
         $display("FAIL word_count got=%0d required=%0d", word_count, wc);
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL missing_writes got=%0d pending required 0", exp_q.size());
      end
   endtask

   task automatic test_reset;
      do_reset;
      vectors++;
      if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_resetn, done, error, word_count} !== '0) begin
         miscompares++;
         $display("FAIL reset_values got=%h required 0",
                  {in_ready, imem_we, imem_addr, imem_wdata, cpu_resetn, done, error, word_count});
      end
      in_valid = 1'b1; in_data = 16'h1234; in_last = 1'b1;
      tick; tick; tick;
      in_valid = 1'b0; in_last = 1'b0;
      vectors++;
      if (in_ready !== 1'b0 || cpu_resetn !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_ignores got ready=%b resetn=%b required 0 0", in_ready, cpu_resetn);
      end
   endtask

   task automatic test_basic;
      prog[0] = 16'h5619; prog[1] = 16'h0193; prog[2] = 16'h4405;
      pulse_start;
      send_prog(3, 1'b1, 1'b0, 16'h0);
      check_release(3);
   endtask

   task automatic test_restart_in_run;
      pulse_start;
      vectors++;
      if (cpu_resetn !== 1'b0 || done !== 1'b0 || word_count !== '0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL run_restart got resetn=%b done=%b wc=%0d ready=%b required 0 0 0 1",
                  cpu_resetn, done, word_count, in_ready);
      end
      prog[0] = 16'haaaa; prog[1] = 16'h5555; prog[2] = 16'h0f0f;
      send_prog(3, 1'b1, 1'b0, 16'h0);
      check_release(3);
   endtask

   task automatic test_toggle;
      for (int i = 0; i < 5; i++) prog[i] = 16'($urandom);
      pulse_start;
      send_prog(5, 1'b1, 1'b1, 16'h0);
      check_release(5);
   endtask

   task automatic test_back_to_back;
      do_reset;
      for (int i = 0; i <= DEPTH; i++) prog[i] = 16'($urandom);
      // start coincides with a valid word; that word must only be taken next cycle
      start = 1'b1; in_valid = 1'b1; in_data = prog[0]; in_last = 1'b0;
      tick;
      start = 1'b0;
      send_prog(DEPTH, 1'b1, 1'b0, 16'h0);
      check_release(DEPTH);
   endtask

   task automatic test_overflow;
      pulse_start;
      send_prog(DEPTH + 1, 1'b0, 1'b0, 16'h0);
      vectors++;
      if (error !== 1'b1 || cpu_resetn !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL overflow got error=%b resetn=%b ready=%b done=%b required 1 0 0 0",
                  error, cpu_resetn, in_ready, done);
      end
      vectors++;
      if (word_count !== (ADDR_W + 1)'(DEPTH)) begin
         miscompares++;
         $display("FAIL overflow_count got=%0d required=%0d", word_count, DEPTH);
      end
      for (int k = 0; k < 10; k++) tick;
      vectors++;
      if (error !== 1'b1 || cpu_resetn !== 1'b0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL error_hold got error=%b resetn=%b pending=%0d required 1 0 0",
                  error, cpu_resetn, exp_q.size());
      end
   endtask

   task automatic test_reset_in_release;
      pulse_start;
      vectors++;
      if (error !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL error_exit got error=%b ready=%b required 0 1", error, in_ready);
      end
      prog[0] = 16'h1111; prog[1] = 16'h2222;
      send_prog(2, 1'b1, 1'b0, 16'h0);
      tick; tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      vectors++;
      if (cpu_resetn !== 1'b0 || done !== 1'b0 || word_count !== '0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release got resetn=%b done=%b wc=%0d ready=%b required 0 0 0 0",
                  cpu_resetn, done, word_count, in_ready);
      end
      for (int k = 0; k < REL + 4; k++) tick;
      vectors++;
      if (cpu_resetn !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset got resetn=%b done=%b required 0 0", cpu_resetn, done);
      end
      prog[0] = 16'hbeef; prog[1] = 16'hcafe;
      pulse_start;
      send_prog(2, 1'b1, 1'b0, 16'h0);
      check_release(2);
   endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   task automatic test_checksum;
      prog[0] = 16'h0001; prog[1] = 16'h0002;
      pulse_start;
      send_prog(2, 1'b1, 1'b0, 16'h0);
      check_release(2);
      pulse_start;
      send_prog(2, 1'b1, 1'b0, 16'h1);
      tick;
      vectors++;
      if (error !== 1'b1 || cpu_resetn !== 1'b0 || word_count !== (ADDR_W + 1)'(2) || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL checksum_bad got error=%b resetn=%b wc=%0d pending=%0d required 1 0 2 0",
                  error, cpu_resetn, word_count, exp_q.size());
      end
   endtask
`endif

   initial begin
      test_reset;
      test_basic;
      test_restart_in_run;
      test_toggle;
      test_back_to_back;
      test_overflow;
      test_reset_in_release;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      test_checksum;
`endif
      tick; tick;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream feeder for `processor_top` instruction memory. Accepts a valid/ready stream of 16-bit instruction words and writes them to consecutive instruction-memory addresses from 0. It holds the processor in reset for the whole load, then releases it after a fixed settle delay. It replaces testbench-driven `instruction_input`/`mem_write` poking with a single hardware load sequence that can be restarted.

## Interface

Parameters:
- `ADDR_W`, 8, instruction-memory address width.
- `DEPTH`, 256, maximum program length in words; must satisfy DEPTH ≤ 2^ADDR_W.
- `RELEASE_CYCLES`, 4, cycles `cpu_resetn` stays low after the last write; minimum 1.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle pulse that begins a load; honoured in IDLE, RUN and ERROR.
- `in_valid` in 1: stream word valid.
- `in_ready` out 1: loader can accept a word.
- `in_data` in 16: instruction word.
- `in_last` in 1: marks the final program word.
- `imem_we` out 1: instruction-memory write enable; drives `mem_write`.
- `imem_addr` out ADDR_W: write address.
- `imem_wdata` out 16: write data; drives `instruction_input`.
- `cpu_resetn` out 1: active-low reset to `processor_top`.
- `done` out 1: high in RUN.
- `error` out 1: high in ERROR.
- `word_count` out ADDR_W+1: number of words written in the current or last load.

## Operation

- States: IDLE, LOAD, CHECK (present only with the macro), RELEASE, RUN, ERROR.
- IDLE: `cpu_resetn`=0 and `in_ready`=0. `start` moves the loader to LOAD and clears `word_count` to 0.
- LOAD: `in_ready`=1. A handshake is `in_valid && in_ready`; on each handshake the loader:
  - writes `in_data` to address `word_count`;
  - increments `word_count`.
- LOAD exits on a handshake with `in_last`=1:
  - without the macro, to RELEASE;
  - with the macro, to CHECK.
- Overflow: a handshake when `word_count`==DEPTH is not written. The loader goes to ERROR.
- Empty program: not possible, because `in_last` always accompanies a written word.
- RELEASE: `in_ready`=0 and `cpu_resetn`=0. An internal counter runs for RELEASE_CYCLES cycles, then the loader goes to RUN.
- RUN: `cpu_resetn`=1, `done`=1, `in_ready`=0. Stream input is ignored. `start` returns the loader to LOAD, asserts `cpu_resetn`=0 on the next cycle, and clears `word_count`.
- ERROR: `cpu_resetn`=0, `error`=1, `in_ready`=0. Only `start` or `reset` leaves this state; `start` goes to LOAD.
- `start` while in LOAD, CHECK or RELEASE is ignored.
- Word count arithmetic: the counter is ADDR_W+1 bits, so the value DEPTH is representable. The address is `word_count[ADDR_W-1:0]`. The address never wraps, because writes stop at DEPTH.

## Timing

- Reset values: state IDLE, `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_resetn`=0, `done`=0, `error`=0, `word_count`=0.
- `reset` mid-load or mid-release returns the loader to IDLE on the next edge. Memory contents are untouched.
- Write latency is 1 cycle: a handshake at edge N produces `imem_we`=1 with the registered addr/data for the cycle after N. `imem_we` is a single-cycle pulse per word.
- Throughput is one word per cycle while `in_valid` is held.
- `in_ready` is registered and is high for the entire LOAD state. It drops on the cycle after the handshake that carried `in_last`.
- Release timing: after the last write pulse, `cpu_resetn` rises exactly RELEASE_CYCLES cycles later. `done` rises in the same cycle.
- Simultaneous `in_valid` and `start` in IDLE: the stream word is not accepted. Acceptance begins the following cycle.

## Configuration

- `PROGRAM_LOADER_CHECKSUM_EN` defined:
  - A 16-bit running sum (mod 2^16) is kept over all written words.
  - After `in_last`, the loader enters CHECK with `in_ready`=1. The next handshake word is the checksum and is not written to memory.
  - Match goes to RELEASE; mismatch goes to ERROR.
  - `in_last` on the checksum word is ignored.
- Undefined: there is no CHECK state and no sum logic. The loader goes from LOAD straight to RELEASE.

## Test plan

- Reset, then `start`, then 3 words 16'h5619, 16'h0193, 16'h4405 with `in_last` on the third → required response:
  - `imem_we` pulses at addr 0, 1, 2 carrying those exact data;
  - `word_count`=3;
  - `cpu_resetn` rises 4 cycles after the third pulse;
  - `done`=1.
- Back-to-back stream of DEPTH words with `in_last` on the last word, then the same with one extra word → first case: addr DEPTH-1 is the last write and the loader reaches RUN. Second case: no write for word DEPTH+1, `error`=1, `cpu_resetn` stays 0.
- `in_valid` toggled every other cycle → only handshake cycles write, and addresses stay contiguous.
- Assert `reset` during RELEASE → `cpu_resetn`=0 and state IDLE. A following `start` reloads a 2-word program correctly.
- `start` pulsed in RUN → `cpu_resetn` falls on the next cycle, `word_count`=0, and the new program is written from addr 0.
- With `PROGRAM_LOADER_CHECKSUM_EN`: words 16'h0001, 16'h0002 followed by checksum 16'h0003 → RUN. The same program with checksum 16'h0004 → ERROR. In both cases `word_count`=2.
